life_engine: RTL and testbench
==============================

// Module: life_engine
// PURPOSE
//  Parametrised Game of Life generation engine (B3/S23 rule) on a ROWS x COLS grid.
//  Holds the live grid in a register and loads it from the top level.
//  Advances one generation per step or free-runs at a programmable rate.
//  Counts generations and detects stable and extinct grids, with an optional auto-halt.
//  Sits between the switch/pattern-load logic and the LED-matrix display driver.
// PARAMETERS
//  ROWS       8   grid rows (>=3)
//  COLS       8   grid columns (>=3)
//  CNT_W      16  generation counter width
//  PERIOD_W   24  width of rate divider / period input
//  AUTO_HALT  1   1: enter HALT when a run tick sees a stable or extinct grid
// PORTS
//  clk        in   1          clock
//  reset      in   1          reset, asynchronous, active-high
//  load       in   1          load load_grid this cycle
//  load_grid  in   ROWS*COLS  initial grid; bit r*COLS+c = cell (r,c), 1=alive
//  start      in   1          begin free-run
//  stop       in   1          stop free-run
//  step       in   1          single generation (IDLE/HALT only)
//  wrap_en    in   1          1: toroidal edges; 0: out-of-grid neighbours dead
//  period     in   PERIOD_W   cycles per generation in RUN (0 treated as 1)
//  grid_out   out  ROWS*COLS  current grid register
//  gen_count  out  CNT_W      generations since last load
//  gen_tick   out  1          1-cycle pulse: grid_out just changed generation
//  running    out  1          state==RUN
//  halted     out  1          state==HALT
//  stable     out  1          comb: next grid == grid_out
//  extinct    out  1          comb: grid_out == 0
// BEHAVIOUR
//  Reset: grid=0, gen_count=0, gen_tick=0, div=0, state=IDLE. Hence stable=1, extinct=1.
//  Next cell: alive if (n==3) or (alive and n==2), where n is the live count of 8 neighbours (4-bit).
//  Neighbour indices wrap modulo ROWS/COLS when wrap_en=1; otherwise they read 0.
//  Input priority each cycle: load > stop > start > step.
//  load (any state): grid<=load_grid, gen_count<=0, div<=0, state<=IDLE. No gen_tick.
//  FSM states {IDLE, RUN, HALT}:
//   IDLE: start->RUN (div<=0). step: update grid at this edge, stay IDLE.
//   RUN:  div counts 0..max(period,1)-1; tick when div==max(period,1)-1, then div<=0.
//         stop->IDLE, no update even on a tick cycle.
//         tick & AUTO_HALT & (stable|extinct)->HALT, no update, gen_count held.
//         tick otherwise: update grid.
//   HALT: start->RUN (div<=0). stop->IDLE. step: update grid, stay HALT.
//  Update: grid<=next, gen_count<=gen_count+1 (wraps modulo 2^CNT_W).
//         gen_tick=1 in the following cycle only.
//  Timing: start sampled in cycle N -> RUN from N+1 -> first update at end of cycle N+max(period,1).
//  period changes mid-run take effect on the next div comparison.
//         If div >= new period-1, tick next cycle.
//  start while RUN, step while RUN: ignored.
//  Reset mid-run: immediate return to reset values; no partial update.
// STRUCTURE
//  life_pkg: state enum life_state_t {IDLE,RUN,HALT}; function cell_next(alive, n).
//  Sub-module life_next_gen #(ROWS,COLS): comb (grid, wrap_en) -> next grid.
//  This sub-module is the datapath; life_engine holds the FSM, grid register, divider and counter.
// TESTING
//  1. 8x8, wrap_en=0, vertical blinker at (3,4)(4,4)(5,4), step -> horizontal (4,3)(4,4)(4,5).
//     step again -> original; gen_count=2; gen_tick pulses twice.
//  2. Block (3,3)(3,4)(4,3)(4,4), start, period=1, AUTO_HALT=1.
//     First tick -> HALT; grid unchanged; gen_count=0; stable=1.
//  3. Glider at top-left, wrap_en=1, period=1, run 32 generations.
//     Grid equals the loaded pattern; gen_count=32.
//  4. Same glider, wrap_en=0.
//     Glider becomes a block at the corner; engine HALTs; stable=1, extinct=0.
//  5. period=3, start in cycle 10 -> updates at end of cycles 13, 16, 19.
//     load in cycle 17 -> IDLE, gen_count=0, no update at 19.
//  6. CNT_W=4, blinker free-run 17 gens -> gen_count=1.
//     Assert reset mid-run -> grid=0, state IDLE, extinct=1 in the same cycle.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and the B3/S23 cell rule for the Game of Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } life_state_t;

    // Birth on exactly 3 neighbours; survival on 2 or 3.
    function automatic logic cell_next(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational next-generation datapath: whole grid in, whole grid out.
module life_next_gen
    import life_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic [ROWS*COLS-1:0] grid_i,
    input  logic                 wrap_en_i,
    output logic [ROWS*COLS-1:0] next_o
);

    localparam int R = int'(ROWS);
    localparam int C = int'(COLS);

    // Off-grid neighbours count as dead unless the edges wrap toroidally.
    function automatic logic [3:0] live_neighbours(input logic [ROWS*COLS-1:0] g,
                                                   input logic wrap, input int r, input int c);
        logic [3:0] n;
        int rr;
        int cc;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (wrap) begin
                    rr = (rr + R) % R;
                    cc = (cc + C) % C;
                end
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < R && cc >= 0 && cc < C) begin
                    n = n + 4'(g[rr*C+cc]);
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        next_o = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                next_o[r*C+c] = cell_next(grid_i[r*C+c], live_neighbours(grid_i, wrap_en_i, r, c));
            end
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: grid register, run/step/halt control, rate divider, generation counter.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PERIOD_W  = 24,
    parameter bit          AUTO_HALT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] load_grid,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    input  logic                 wrap_en,
    input  logic [PERIOD_W-1:0]  period,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic [CNT_W-1:0]     gen_count,
    output logic                 gen_tick,
    output logic                 running,
    output logic                 halted,
    output logic                 stable,
    output logic                 extinct
);

    localparam int unsigned N = ROWS * COLS;

    life_state_t         state_q;
    logic [N-1:0]        grid_q;
    logic [N-1:0]        next_grid;
    logic [CNT_W-1:0]    gen_q;
    logic [PERIOD_W-1:0] div_q;
    logic [PERIOD_W-1:0] last_div;
    logic                tick_q;
    logic                tick;
    logic                halt_now;
    logic                do_update;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS)) u_next_gen (
        .grid_i    (grid_q),
        .wrap_en_i (wrap_en),
        .next_o    (next_grid)
    );

    // A period of 0 behaves like 1; '>=' lets a shortened period tick immediately.
    assign last_div = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick     = (div_q >= last_div);
    assign halt_now = AUTO_HALT && (stable || extinct);

    always_comb begin
        do_update = 1'b0;
        if (!load && !stop) begin
            if (state_q == RUN) begin
                do_update = tick && !halt_now;
            end else begin
                do_update = !start && step;
            end
        end
    end

    assign grid_out  = grid_q;
    assign gen_count = gen_q;
    assign gen_tick  = tick_q;
    assign running   = (state_q == RUN);
    assign halted    = (state_q == HALT);
    assign stable    = (next_grid == grid_q);
    assign extinct   = (grid_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            gen_q   <= '0;
            div_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= do_update;
            if (do_update) begin
                grid_q <= next_grid;
                gen_q  <= gen_q + CNT_W'(1);
            end
            if (load) begin
                grid_q  <= load_grid;
                gen_q   <= '0;
                div_q   <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, HALT: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (start) begin
                            state_q <= RUN;
                            div_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (tick) begin
                            div_q <= '0;
                            if (halt_now) state_q <= HALT;
                        end else begin
                            div_q <= div_q + PERIOD_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboarded bench for life_engine against a cell-by-cell Game of Life reference model.
module tb_life_engine;

    localparam int R = 8;
    localparam int C = 8;
    typedef logic [63:0] grid_t;
    typedef struct {
        grid_t grid;
        int    gen;
        int    cyc;
    } exp_t;

    localparam grid_t BLINK_V = (64'd1 << 28) | (64'd1 << 36) | (64'd1 << 44);
    localparam grid_t BLINK_H = (64'd1 << 35) | (64'd1 << 36) | (64'd1 << 37);
    localparam grid_t BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
    localparam grid_t GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);

    logic        clk;
    logic        reset;
    logic        load;
    grid_t       load_grid;
    logic        start;
    logic        stop;
    logic        step;
    logic        wrap_en;
    logic [23:0] period;
    grid_t       grid_out;
    grid_t       grid_out4;
    logic [15:0] gen_count;
    logic [3:0]  gen_count4;
    logic        gen_tick, gen_tick4;
    logic        running, running4;
    logic        halted, halted4;
    logic        stable, stable4;
    logic        extinct, extinct4;

    life_engine #(.ROWS(8), .COLS(8), .CNT_W(16), .PERIOD_W(24), .AUTO_HALT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .load(load), .load_grid(load_grid), .start(start),
        .stop(stop), .step(step), .wrap_en(wrap_en), .period(period), .grid_out(grid_out),
        .gen_count(gen_count), .gen_tick(gen_tick), .running(running), .halted(halted),
        .stable(stable), .extinct(extinct)
    );

    life_engine #(.ROWS(8), .COLS(8), .CNT_W(4), .PERIOD_W(24), .AUTO_HALT(1'b1)) u_dut4 (
        .clk(clk), .reset(reset), .load(load), .load_grid(load_grid), .start(start),
        .stop(stop), .step(step), .wrap_en(wrap_en), .period(period), .grid_out(grid_out4),
        .gen_count(gen_count4), .gen_tick(gen_tick4), .running(running4), .halted(halted4),
        .stable(stable4), .extinct(extinct4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    errors = 0;
    int    checks = 0;
    int    ticks_seen = 0;
    exp_t  q[$];
    grid_t mgrid;
    int    mgen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: count the eight neighbours of each cell from an offset table.
    function automatic grid_t ref_next(input grid_t g, input bit wrap);
        int    offs_r[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int    offs_c[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        grid_t res = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int n = 0;
                for (int k = 0; k < 8; k++) begin
                    int rr = r + offs_r[k];
                    int cc = c + offs_c[k];
                    if (wrap) begin
                        rr = (rr + R) % R;
                        cc = (cc + C) % C;
                    end
                    if (rr >= 0 && rr < R && cc >= 0 && cc < C && g[rr*C+cc]) n++;
                end
                res[r*C+c] = (n == 3) || (g[r*C+c] && n == 2);
            end
        end
        return res;
    endfunction

    // Monitor: every gen_tick must match the oldest expected generation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && gen_tick) begin
                ticks_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: gen_tick=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("tick_grid", grid_out, e.grid);
                    chk("tick_gen", 64'(gen_count), 64'(e.gen));
                    chk("tick_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            cyc_step();
            k++;
        end
        chk("pending_ticks", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic do_load(input grid_t g);
        drain();
        load      = 1'b1;
        load_grid = g;
        cyc_step();
        load  = 1'b0;
        mgrid = g;
        mgen  = 0;
    endtask

    task automatic do_step();
        exp_t e;
        mgrid = ref_next(mgrid, wrap_en);
        mgen++;
        e.grid = mgrid;
        e.gen  = mgen;
        e.cyc  = cyc + 1;
        q.push_back(e);
        step = 1'b1;
        cyc_step();
        step = 1'b0;
    endtask

    // Free-run up to n generations, predicting the tick cycles and any auto-halt.
    task automatic run_gens(input int n, input int p, output bit halted_pred);
        int    pe = (p == 0) ? 1 : p;
        int    n0 = cyc;
        int    halt_at = -1;
        int    target;
        grid_t nxt;
        exp_t  e;
        period = 24'(p);
        start  = 1'b1;
        for (int k = 1; k <= n; k++) begin
            nxt = ref_next(mgrid, wrap_en);
            if (nxt == mgrid || mgrid == '0) begin
                halt_at = n0 + k * pe;
                break;
            end
            mgrid  = nxt;
            mgen++;
            e.grid = mgrid;
            e.gen  = mgen;
            e.cyc  = n0 + k * pe + 1;
            q.push_back(e);
        end
        cyc_step();
        start = 1'b0;
        halted_pred = (halt_at >= 0);
        target = halted_pred ? halt_at + 1 : n0 + n * pe + 1;
        while (cyc < target) cyc_step();
        if (halted_pred) begin
            chk("halt_state", 64'(halted), 64'd1);
            chk("halt_grid", grid_out, mgrid);
            chk("halt_gen", 64'(gen_count), 64'(mgen));
            chk("halt_stable_or_extinct", 64'(stable | extinct), 64'd1);
        end else begin
            stop = 1'b1;
            cyc_step();
            stop = 1'b0;
            chk("stopped_idle", 64'({running, halted}), 64'd0);
        end
        drain();
    endtask

    initial begin
        bit h;
        int t0;
        int n0;
        exp_t e;
        reset = 1'b1; load = 1'b0; load_grid = '0; start = 1'b0; stop = 1'b0;
        step = 1'b0; wrap_en = 1'b0; period = 24'd1;
        mgrid = '0; mgen = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_grid", grid_out, '0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_tick", 64'(gen_tick), 64'd0);
        chk("rst_state", 64'({running, halted}), 64'd0);
        chk("rst_stable_extinct", 64'({stable, extinct}), 64'b11);

        // Blinker stepping with hard edges.
        wrap_en = 1'b0;
        do_load(BLINK_V);
        t0 = ticks_seen;
        do_step();
        cyc_step();
        chk("blink_h", grid_out, BLINK_H);
        do_step();
        cyc_step();
        chk("blink_v", grid_out, BLINK_V);
        chk("blink_gen", 64'(gen_count), 64'd2);
        chk("blink_ticks", 64'(ticks_seen - t0), 64'd2);

        // Still life halts on the first tick.
        do_load(BLOCK);
        run_gens(4, 1, h);
        chk("block_halt", 64'({halted, stable}), 64'b11);
        chk("block_gen", 64'(gen_count), 64'd0);
        chk("block_grid", grid_out, BLOCK);

        // Glider on a torus returns home after 32 generations.
        wrap_en = 1'b1;
        do_load(GLIDER);
        run_gens(32, 1, h);
        chk("glider_wrap_grid", grid_out, GLIDER);
        chk("glider_wrap_gen", 64'(gen_count), 64'd32);

        // Without wrap the glider settles into a corner block.
        wrap_en = 1'b0;
        do_load(GLIDER);
        run_gens(80, 1, h);
        chk("glider_edge_halt", 64'(halted), 64'd1);
        chk("glider_edge_flags", 64'({stable, extinct}), 64'b10);

        // period=3 timing, then a load mid-run cancels the pending update.
        do_load(BLINK_V);
        n0 = cyc;
        period = 24'd3;
        start = 1'b1;
        e.grid = BLINK_H; e.gen = 1; e.cyc = n0 + 4; q.push_back(e);
        e.grid = BLINK_V; e.gen = 2; e.cyc = n0 + 7; q.push_back(e);
        cyc_step();
        start = 1'b0;
        while (cyc < n0 + 7) cyc_step();
        load = 1'b1;
        load_grid = BLINK_V;
        cyc_step();
        load = 1'b0;
        mgrid = BLINK_V; mgen = 0;
        while (cyc < n0 + 13) cyc_step();
        chk("p3_load_gen", 64'(gen_count), 64'd0);
        chk("p3_load_state", 64'({running, halted}), 64'd0);
        chk("p3_pending", 64'(q.size()), 64'd0);

        // Narrow counter wraps; reset mid-run clears everything at once.
        do_load(BLINK_V);
        run_gens(17, 1, h);
        chk("cnt16_gen", 64'(gen_count), 64'd17);
        chk("cnt4_gen", 64'(gen_count4), 64'd1);
        chk("cnt4_grid", grid_out4, grid_out);
        do_load(BLINK_V);
        period = 24'd1000;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        repeat (3) cyc_step();
        chk("pre_reset_running", 64'(running), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_grid", grid_out, '0);
        chk("midrst_state", 64'({running, halted}), 64'd0);
        chk("midrst_extinct", 64'(extinct), 64'd1);
        chk("midrst_gen4", 64'(gen_count4), 64'd0);
        cyc_step();
        reset = 1'b0;
        mgrid = '0; mgen = 0;

        // Random grids, edge modes, periods and step/run mixes.
        for (int t = 0; t < 14; t++) begin
            wrap_en = 1'($urandom_range(0, 1));
            do_load({$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) do_step();
            end else begin
                run_gens(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), h);
                if (h) do_step();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
